can_bit_timing: RTL and testbench

Bit-timing controller that sequences the CAN receive datapath. It divides `clk` into time quanta, tracks the SYNC/TSEG1/TSEG2 segments of each nominal bit, and hard-syncs or resyncs on recessive-to-dominant bus edges. It emits a one-cycle `sample_point` pulse with the sampled `rx_bit` to `can_decoder`, plus a `tx_point` pulse for a future transmitter. It sits between the synchronised bus pin and the decoder and replaces free-running sample-point generation.

---
 rtl/can_pkg.sv | 23 ++
 rtl/can_tq_prescaler.sv | 35 +++
 rtl/can_bit_timing.sv | 253 +++++++++++++++++++++++++
 tb/tb_can_bit_timing.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// can_pkg
//   Shared definitions for the CAN bit-timing slice.
//   - Default parameter widths for the bit-timing configuration ports.
//   - Bus level names (RECESSIVE / DOMINANT).
//   - Bit-timing FSM state encoding.
package can_pkg;

  localparam int BRP_W_DEF   = 6;
  localparam int TSEG1_W_DEF = 4;
  localparam int TSEG2_W_DEF = 3;
  localparam int SJW_W_DEF   = 2;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TSEG1 = 2'd2,
    TSEG2 = 2'd3
  } bt_state_t;

endpackage

// File: rtl/can_tq_prescaler.sv
// can_tq_prescaler
//   Divides clk by (brp+1) to produce the time-quantum tick.
//   Ports:
//     clk     : clock
//     rst     : synchronous, active-low reset
//     clear   : restart the quantum at count 0 on the next clk
//     brp     : prescaler value; one tq = brp+1 clk
//     tq_tick : high on the last clk of each tq
module can_tq_prescaler
  import can_pkg::*;
#(
  parameter int BRP_W = BRP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [BRP_W-1:0] brp,
  output logic             tq_tick
);

  logic [BRP_W-1:0] count;

  assign tq_tick = (count == brp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || tq_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/can_bit_timing.sv
// can_bit_timing
//   CAN nominal bit-timing controller. Splits each bit into SYNC / TSEG1 /
//   TSEG2 time quanta, hard-syncs or resyncs on recessive-to-dominant edges
//   and marks the sample point for the decoder.
//   Ports:
//     clk, rst     : clock, synchronous active-low reset
//     enable       : run; low forces IDLE. Config latches on its rising edge.
//     brp          : tq = brp+1 clk
//     tseg1        : TSEG1 = tseg1+1 tq (values below 1 are treated as 1)
//     tseg2        : TSEG2 = tseg2+1 tq (values below 1 are treated as 1)
//     sjw          : SJW = min(sjw, tseg2)+1 tq
//     rx           : raw asynchronous bus level
//     bus_idle     : 1 lets an edge hard-sync instead of resync
//     rx_bit       : bus value captured at the last sample point
//     sample_point : one-cycle pulse, the clk after the last clk of TSEG1,
//                    coinciding with the updated rx_bit
//     tx_point     : one-cycle pulse on the first clk of SYNC
//     hard_synced  : one-cycle pulse after a hard sync was taken
//   The enum signal `state` is the FSM state for checkers to observe.
//   Width assumption: SJW_W and TSEG2_W do not exceed TSEG1_W+1.
module can_bit_timing
  import can_pkg::*;
#(
  parameter int BRP_W   = BRP_W_DEF,
  parameter int TSEG1_W = TSEG1_W_DEF,
  parameter int TSEG2_W = TSEG2_W_DEF,
  parameter int SJW_W   = SJW_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [BRP_W-1:0]   brp,
  input  logic [TSEG1_W-1:0] tseg1,
  input  logic [TSEG2_W-1:0] tseg2,
  input  logic [SJW_W-1:0]   sjw,
  input  logic               rx,
  input  logic               bus_idle,
  output logic               rx_bit,
  output logic               sample_point,
  output logic               tx_point,
  output logic               hard_synced
);

  // Wide enough for a TSEG1 terminal index plus the largest late extension.
  localparam int CNT_W = ((TSEG1_W > TSEG2_W) ? TSEG1_W : TSEG2_W) + 1;

  // Synchroniser and latched configuration
  logic             rx_meta;
  logic             rx_s;
  logic             en_d;
  logic [BRP_W-1:0] cfg_brp;
  logic [CNT_W-1:0] cfg_t1;      // TSEG1 terminal tq index
  logic [CNT_W-1:0] cfg_t2;      // TSEG2 terminal tq index
  logic [CNT_W-1:0] cfg_sjw_tq;  // effective SJW in tq

  logic [CNT_W-1:0] t1_req;
  logic [CNT_W-1:0] t2_req;
  logic [CNT_W-1:0] sjw_req;
  logic [CNT_W-1:0] sjw_min;

  assign t1_req  = (tseg1 == '0) ? CNT_W'(1) : CNT_W'(tseg1);
  assign t2_req  = (tseg2 == '0) ? CNT_W'(1) : CNT_W'(tseg2);
  assign sjw_req = CNT_W'(sjw);
  assign sjw_min = (sjw_req < t2_req) ? sjw_req : t2_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta    <= RECESSIVE;
      rx_s       <= RECESSIVE;
      en_d       <= 1'b0;
      cfg_brp    <= '0;
      cfg_t1     <= '0;
      cfg_t2     <= '0;
      cfg_sjw_tq <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      en_d    <= enable;
      if (enable && !en_d) begin
        cfg_brp    <= brp;
        cfg_t1     <= t1_req;
        cfg_t2     <= t2_req;
        cfg_sjw_tq <= sjw_min + CNT_W'(1);
      end
    end
  end

  // FSM state, segment counter and edge bookkeeping
  bt_state_t        state, state_n;
  logic [CNT_W-1:0] tq_cnt, tq_cnt_n;
  logic [CNT_W-1:0] seg_end, seg_end_n;   // terminal tq index of current segment
  logic [CNT_W-1:0] end_eff;              // seg_end after this clk's resync
  logic             edge_taken, edge_taken_n;
  logic             rx_bit_n;
  logic             sample_point_n;
  logic             tx_point_n;
  logic             hard_synced_n;

  logic             presc_clr;
  logic             tq_tick;
  logic             edge_valid;
  logic             hard_sync;
  logic             resync;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] late_ext;

  can_tq_prescaler #(
    .BRP_W(BRP_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear   (presc_clr),
    .brp     (cfg_brp),
    .tq_tick (tq_tick)
  );

  // An edge is a dominant level while the last sampled bit was recessive;
  // only the first one per bit (until the next sample point) counts.
  assign edge_valid = (rx_s == DOMINANT) && (rx_bit == RECESSIVE) && !edge_taken;
  assign hard_sync  = edge_valid && bus_idle && (state != IDLE);
  assign resync     = edge_valid && !bus_idle;

  // tq left in TSEG2 including the current one.
  assign remaining = seg_end - tq_cnt + CNT_W'(1);
  // Late-edge extension: phase error (k+1) limited to SJW.
  assign late_ext  = ((tq_cnt + CNT_W'(1)) < cfg_sjw_tq) ? (tq_cnt + CNT_W'(1)) : cfg_sjw_tq;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      tq_cnt       <= '0;
      seg_end      <= '0;
      edge_taken   <= 1'b0;
      rx_bit       <= RECESSIVE;
      sample_point <= 1'b0;
      tx_point     <= 1'b0;
      hard_synced  <= 1'b0;
    end else begin
      state        <= state_n;
      tq_cnt       <= tq_cnt_n;
      seg_end      <= seg_end_n;
      edge_taken   <= edge_taken_n;
      rx_bit       <= rx_bit_n;
      sample_point <= sample_point_n;
      tx_point     <= tx_point_n;
      hard_synced  <= hard_synced_n;
    end
  end

  always_comb begin
    state_n        = state;
    tq_cnt_n       = tq_cnt;
    seg_end_n      = seg_end;
    end_eff        = seg_end;
    edge_taken_n   = edge_taken;
    rx_bit_n       = rx_bit;
    sample_point_n = 1'b0;
    tx_point_n     = 1'b0;
    hard_synced_n  = 1'b0;
    presc_clr      = 1'b0;

    if (!enable) begin
      state_n      = IDLE;
      tq_cnt_n     = '0;
      seg_end_n    = '0;
      edge_taken_n = 1'b0;
      presc_clr    = 1'b1;
    end else if (hard_sync) begin
      // The tq holding the edge stands in for SYNC; TSEG1 starts fresh.
      state_n       = TSEG1;
      tq_cnt_n      = '0;
      seg_end_n     = cfg_t1;
      edge_taken_n  = 1'b1;
      hard_synced_n = 1'b1;
      presc_clr     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_n      = SYNC;
          tq_cnt_n     = '0;
          seg_end_n    = '0;
          edge_taken_n = 1'b0;
          tx_point_n   = 1'b1;
          presc_clr    = 1'b1;
        end

        SYNC: begin
          // An edge inside SYNC is already in phase: consume it, no jump.
          if (resync) begin
            edge_taken_n = 1'b1;
          end
          if (tq_tick) begin
            state_n   = TSEG1;
            tq_cnt_n  = '0;
            seg_end_n = cfg_t1;
          end
        end

        TSEG1: begin
          if (resync) begin
            end_eff      = seg_end + late_ext;
            edge_taken_n = 1'b1;
          end
          seg_end_n = end_eff;
          if (tq_tick) begin
            if (tq_cnt == end_eff) begin
              state_n        = TSEG2;
              tq_cnt_n       = '0;
              seg_end_n      = cfg_t2;
              sample_point_n = 1'b1;
              rx_bit_n       = rx_s;
              edge_taken_n   = 1'b0;
            end else begin
              tq_cnt_n = tq_cnt + CNT_W'(1);
            end
          end
        end

        TSEG2: begin
          if (resync && (remaining <= cfg_sjw_tq)) begin
            // Early edge close to the bit end: this edge becomes SYNC.
            state_n      = TSEG1;
            tq_cnt_n     = '0;
            seg_end_n    = cfg_t1;
            edge_taken_n = 1'b1;
            presc_clr    = 1'b1;
          end else begin
            if (resync) begin
              end_eff      = seg_end - cfg_sjw_tq;
              edge_taken_n = 1'b1;
            end
            seg_end_n = end_eff;
            if (tq_tick) begin
              if (tq_cnt == end_eff) begin
                state_n    = SYNC;
                tq_cnt_n   = '0;
                seg_end_n  = '0;
                tx_point_n = 1'b1;
              end else begin
                tq_cnt_n = tq_cnt + CNT_W'(1);
              end
            end
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_bit_timing.sv
// tb_can_bit_timing
//   Directed bench for can_bit_timing. Expected cycle distances and levels
//   are queued when the stimulus is applied and popped when the matching
//   DUT pulse is observed (outputs sampled on the falling clock edge).
module tb_can_bit_timing;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] brp = 6'd0;
  logic [3:0] tseg1 = 4'd2;
  logic [2:0] tseg2 = 3'd1;
  logic [1:0] sjw = 2'd0;
  logic       rx = 1'b1;
  logic       bus_idle = 1'b0;
  logic       rx_bit;
  logic       sample_point;
  logic       tx_point;
  logic       hard_synced;

  can_bit_timing #(
    .BRP_W(6), .TSEG1_W(4), .TSEG2_W(3), .SJW_W(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .brp          (brp),
    .tseg1        (tseg1),
    .tseg2        (tseg2),
    .sjw          (sjw),
    .rx           (rx),
    .bus_idle     (bus_idle),
    .rx_bit       (rx_bit),
    .sample_point (sample_point),
    .tx_point     (tx_point),
    .hard_synced  (hard_synced)
  );

  // Clock / cycle count
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_check(input string tag, input int got);
    int e;
    if (exp_q.size() == 0) e = -999;
    else e = int'(exp_q.pop_front());
    check_eq(tag, got, e);
  endtask

  // Driver helpers
  task automatic drive_after(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sel: 0 sample_point, 1 tx_point, 2 hard_synced. at = -1 on timeout.
  task automatic wait_pulse(input int sel, input int budget, output int at, output int n_tx);
    logic hit;
    at = -1;
    n_tx = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      hit = (sel == 0) ? sample_point : (sel == 1) ? tx_point : hard_synced;
      if (hit) begin
        at = cyc;
        break;
      end
      if (tx_point) n_tx++;
    end
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sample_point) cnt++;
      if (tx_point) cnt++;
      if (hard_synced) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s, s0, s1, s2, p, h, d, ntx, np;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(1); sb_check("reset_rx_bit", rx_bit);
    exp_q.push_back(0); sb_check("reset_sample_point", sample_point);
    exp_q.push_back(0); sb_check("reset_tx_point", tx_point);
    exp_q.push_back(0); sb_check("reset_hard_synced", hard_synced);
    drive_after(1); rst = 1'b1;
    drive_after(1); enable = 1'b1;

    // Legacy cadence: brp=0, tseg1=2, tseg2=1 -> 6 clk bit
    wait_pulse(1, 100, t, ntx);
    exp_q.push_back(4);
    wait_pulse(0, 100, s0, ntx);
    sb_check("legacy_tx_to_sp", s0 - t);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(6);
      wait_pulse(0, 100, s1, ntx);
      sb_check("legacy_period", s1 - s0);
      s0 = s1;
    end
    exp_q.push_back(1); sb_check("legacy_rx_bit", rx_bit);

    // Hard sync in TSEG2: edge seen 2 clk after rx drop, hard_synced next clk
    wait_pulse(1, 100, t, ntx);
    drive_after(2); bus_idle = 1'b1; rx = 1'b0; d = cyc;
    exp_q.push_back(3);
    exp_q.push_back(3);
    exp_q.push_back(0);
    wait_pulse(2, 100, h, ntx);
    sb_check("hs_latency", h - d);
    wait_pulse(0, 100, s, ntx);
    sb_check("hs_to_sp", s - h);
    sb_check("hs_rx_bit", rx_bit);
    drive_after(1); bus_idle = 1'b0; rx = 1'b1;
    wait_pulse(0, 100, s, ntx);
    wait_pulse(0, 100, s, ntx);
    exp_q.push_back(1); sb_check("restored_rx_bit", rx_bit);

    // Late edge: brp=1, tseg1=5, tseg2=3, sjw=1 (SJW 2 tq)
    drive_after(1); enable = 1'b0; brp = 6'd1; tseg1 = 4'd5; tseg2 = 3'd3; sjw = 2'd1;
    drive_after(3); enable = 1'b1;
    wait_pulse(0, 100, s0, ntx);
    exp_q.push_back(22);
    wait_pulse(0, 100, s1, ntx);
    sb_check("nominal_period", s1 - s0);
    wait_pulse(1, 100, t, ntx);
    // rx_s falls 8 clk after SYNC start: TSEG1 tq 3
    drive_after(6); rx = 1'b0;
    exp_q.push_back(26);
    exp_q.push_back(0);
    wait_pulse(0, 100, s, ntx);
    sb_check("late_period", s - s1);
    sb_check("late_rx_bit", rx_bit);
    drive_after(1); rx = 1'b1;
    wait_pulse(0, 100, s, ntx);
    wait_pulse(0, 100, s, ntx);

    // Early edge: rx_s falls at TSEG2 tq 2 (r=2) -> straight into TSEG1 (12 clk)
    wait_pulse(0, 100, p, ntx);
    drive_after(2); rx = 1'b0; d = cyc;
    exp_q.push_back(2 + 1 + 12);
    exp_q.push_back(0);
    exp_q.push_back(17);
    wait_pulse(0, 100, s, ntx);
    sb_check("early_edge_to_sp", s - d);
    sb_check("early_no_tx", ntx);
    sb_check("early_period", s - p);
    drive_after(1); rx = 1'b1;
    wait_pulse(0, 100, s, ntx);
    wait_pulse(0, 100, s, ntx);

    // Glitch 1-0-1-0 inside TSEG1: only the first edge may resync
    wait_pulse(0, 100, p, ntx);
    wait_pulse(1, 100, t, ntx);
    drive_after(6); rx = 1'b0;
    drive_after(2); rx = 1'b1;
    drive_after(2); rx = 1'b0;
    exp_q.push_back(26);
    wait_pulse(0, 100, s, ntx);
    sb_check("double_edge_period", s - p);

    // enable dropped mid-TSEG1: quiet, rx_bit holds
    wait_pulse(1, 100, t, ntx);
    drive_after(4); enable = 1'b0; rx = 1'b1;
    count_pulses(30, np);
    exp_q.push_back(0); sb_check("disabled_pulses", np);
    exp_q.push_back(0); sb_check("disabled_rx_bit_hold", rx_bit);
    drive_after(1); brp = 6'd3; tseg1 = 4'd2; tseg2 = 3'd1; sjw = 2'd0; enable = 1'b1; d = cyc;
    exp_q.push_back(1);
    exp_q.push_back(16);
    exp_q.push_back(24);
    wait_pulse(1, 100, t, ntx);
    sb_check("enable_to_tx", t - d);
    wait_pulse(0, 100, s0, ntx);
    sb_check("reenable_tx_to_sp", s0 - t);
    wait_pulse(0, 100, s1, ntx);
    sb_check("reenable_period", s1 - s0);
    brp = 6'd0; tseg1 = 4'd7;
    exp_q.push_back(24);
    wait_pulse(0, 100, s2, ntx);
    sb_check("cfg_change_ignored", s2 - s1);

    // Reset on the clk a sample point would have fired
    rx = 1'b0;
    wait_pulse(0, 100, s, ntx);
    wait_pulse(0, 100, s, ntx);
    exp_q.push_back(0); sb_check("pre_reset_rx_bit", rx_bit);
    wait_pulse(1, 100, t, ntx);
    drive_after(15); rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back(1); sb_check("midbit_reset_rx_bit", rx_bit);
    exp_q.push_back(0); sb_check("midbit_reset_sample_point", sample_point);
    exp_q.push_back(0); sb_check("midbit_reset_tx_point", tx_point);
    exp_q.push_back(0); sb_check("midbit_reset_hard_synced", hard_synced);
    count_pulses(3, np);
    exp_q.push_back(0); sb_check("in_reset_pulses", np);
    drive_after(1); rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
